// File: rtl/sha256_round_ctrl_pkg.sv
// Shared types and constants for the SHA-256 round controller and datapath:
// FSM state encoding, round count, initial hash value and round constants.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int ROUNDS_C = 64;

    localparam logic [31:0] IV_C [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_C [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Round constant lookup for the compression datapath, indexed by round_o.
    function automatic logic [31:0] k_of(input logic [5:0] idx);
        return K_C[idx];
    endfunction

endpackage

// File: rtl/sha256_round_ctr.sv
// Round index counter: synchronous clear (priority), enable, and a terminal
// flag raised while the index equals ROUNDS-1.
module sha256_round_ctr #(
    parameter int ROUNDS = 64,
    parameter int RND_W  = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [RND_W-1:0] cnt_o,
    output logic             term_o
);

    logic [RND_W-1:0] cnt_d;
    logic [RND_W-1:0] cnt_q;

    // Next count: clear wins over increment so the index never wraps.
    always_comb begin
        if (clr_i) begin
            cnt_d = {RND_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + RND_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= {RND_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == RND_W'(ROUNDS - 1));

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencer: accept -> LOAD -> ROUNDS x ROUND -> UPDATE -> (DONE).
// Optional macro SHA256_CTRL_ABORT_EN adds abort_i, which returns any busy state to IDLE.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int ROUNDS  = ROUNDS_C,
    parameter int BLOCK_W = 512,
    parameter int RND_W   = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic               last_i,
    output logic               sched_init_o,
    output logic [BLOCK_W-1:0] sched_M_o,
    output logic               comp_load_o,
    output logic               h_init_o,
    output logic [RND_W-1:0]   round_o,
    output logic               round_v_o,
    output logic               h_update_o,
    output logic               v_o,
    input  logic               yumi_i
`ifdef SHA256_CTRL_ABORT_EN
    ,
    input  logic               abort_i
`endif
);

    state_e             state_d, state_q;
    logic               first_d, first_q;
    logic               last_d, last_q;
    logic [BLOCK_W-1:0] m_d, m_q;
    logic               v_d, v_q;
    logic               ctr_clr_s;
    logic               ctr_en_s;
    logic               term_s;

    sha256_round_ctr #(
        .ROUNDS (ROUNDS),
        .RND_W  (RND_W)
    ) u_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (ctr_clr_s),
        .en_i    (ctr_en_s),
        .cnt_o   (round_o),
        .term_o  (term_s)
    );

    assign ctr_en_s = (state_q == ST_ROUND);

    // Next-state, message-position and block-capture logic.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        last_d    = last_q;
        m_d       = m_q;
        ctr_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    m_d     = block_i;
                    last_d  = last_i;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ctr_clr_s = 1'b1;
                state_d   = ST_ROUND;
            end
            ST_ROUND: begin
                if (term_s) begin
                    ctr_clr_s = 1'b1;
                    state_d   = ST_UPDATE;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_UPDATE: begin
                first_d = 1'b0;
                if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                // A new message restarts from the IV once the digest is taken.
                if (yumi_i) begin
                    first_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                ctr_clr_s = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
`ifdef SHA256_CTRL_ABORT_EN
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            first_d   = 1'b1;
            last_d    = 1'b0;
            ctr_clr_s = 1'b1;
        end else begin
        end
`endif
        v_d = (state_d == ST_DONE);
    end

    // Controller state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            m_q     <= {BLOCK_W{1'b0}};
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            m_q     <= m_d;
            v_q     <= v_d;
        end
    end

    // ready_o is gated by reset because the state already reads IDLE during reset.
    assign ready_o      = (state_q == ST_IDLE) & ~reset_i;
    assign sched_init_o = (state_q == ST_LOAD);
    assign comp_load_o  = (state_q == ST_LOAD);
    assign h_init_o     = (state_q == ST_LOAD) & first_q;
    assign round_v_o    = (state_q == ST_ROUND);
    assign h_update_o   = (state_q == ST_UPDATE);
    assign sched_M_o    = m_q;
    assign v_o          = v_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: the driver pushes expected block
// records from a message-level model; a negedge monitor pops and checks them.
module tb_sha256_round_ctrl;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic         ready_o;
    logic [511:0] block_i;
    logic         last_i;
    logic         sched_init_o;
    logic [511:0] sched_M_o;
    logic         comp_load_o;
    logic         h_init_o;
    logic [5:0]   round_o;
    logic         round_v_o;
    logic         h_update_o;
    logic         v_o;
    logic         yumi_i;
`ifdef SHA256_CTRL_ABORT_EN
    logic         abort_i;
`endif

    sha256_round_ctrl dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .block_i      (block_i),
        .last_i       (last_i),
        .sched_init_o (sched_init_o),
        .sched_M_o    (sched_M_o),
        .comp_load_o  (comp_load_o),
        .h_init_o     (h_init_o),
        .round_o      (round_o),
        .round_v_o    (round_v_o),
        .h_update_o   (h_update_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i)
`ifdef SHA256_CTRL_ABORT_EN
        ,
        .abort_i      (abort_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] blk;
        logic         last;
        logic         h_init;
        int           acc;
    } rec_t;

    rec_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   model_first = 1'b1;
    int   prev_acc = -1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [511:0] rnd_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Offer a block until accepted; on accept, push the model's expectation.
    task automatic send_block(input logic [511:0] b, input logic l, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        v_i = 1'b1; block_i = b; last_i = l;
        for (int w = 0; w < 300; w++) begin
            #2;
            if (ready_o) begin
                ok  = 1'b1;
                acc = cyc;
                step();
                break;
            end
            step();
        end
        v_i = 1'b0;
        chk("accept_timeout", ok, 1'b1);
        if (ok) begin
            q.push_back('{blk: b, last: l, h_init: model_first, acc: acc});
            if (prev_acc >= 0) chk("blk_spacing", (acc - prev_acc) >= 67, 1'b1);
            prev_acc    = acc;
            model_first = l;
        end
    endtask

    task automatic wait_vo();
        for (int w = 0; w < 200; w++) begin
            if (v_o) break;
            step();
        end
        chk("vo_timeout", v_o, 1'b1);
    endtask

    task automatic take_digest();
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
    endtask

    task automatic wait_round(input int r);
        for (int w = 0; w < 200; w++) begin
            if (round_v_o && round_o == 6'(r)) break;
            step();
        end
        chk("wait_round", round_o, 6'(r));
    endtask

    // Monitor: pops one expectation per LOAD and tracks the block to completion.
    initial begin : monitor
        rec_t cur;
        bit   cur_active, cur_valid, dig_pending, v_prev;
        int   rounds_seen, done_exp;
        cur_active = 1'b0; cur_valid = 1'b0; dig_pending = 1'b0; v_prev = 1'b0;
        rounds_seen = 0; done_exp = -1;
        cur = '{blk: '0, last: 1'b0, h_init: 1'b0, acc: 0};
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                chk("reset_outs", {ready_o, v_o, sched_init_o, comp_load_o, h_init_o,
                                   round_v_o, h_update_o, round_o}, '0);
                chk("reset_sched_M", sched_M_o, '0);
                cur_active = 1'b0; cur_valid = 1'b0; dig_pending = 1'b0;
            end else begin
                chk("ready_o", ready_o, (q.size() == 0) && !cur_active && !dig_pending);
                chk("v_o", v_o, dig_pending);
                if (sched_init_o) begin
                    chk("load_expected", q.size() != 0, 1'b1);
                    chk("load_busy", cur_active, 1'b0);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        cur_valid = 1'b1; cur_active = 1'b1; rounds_seen = 0;
                        chk("h_init_o", h_init_o, cur.h_init);
                        chk("comp_load_o", comp_load_o, 1'b1);
                        chk("load_latency", cyc - cur.acc, 1);
                    end
                end else begin
                    chk("load_idle", {comp_load_o, h_init_o}, 2'b00);
                end
                if (cur_valid) chk("sched_M_o", sched_M_o, cur.blk);
                if (round_v_o) begin
                    chk("round_active", cur_active, 1'b1);
                    chk("round_o", round_o, rounds_seen);
                    rounds_seen++;
                end else begin
                    chk("round_idle", round_o, 6'd0);
                end
                if (h_update_o) begin
                    chk("update_active", cur_active, 1'b1);
                    chk("update_latency", cyc - cur.acc, 66);
                    chk("round_count", rounds_seen, 64);
                    cur_active = 1'b0;
                    if (cur.last) begin
                        dig_pending = 1'b1;
                        done_exp    = cur.acc + 67;
                    end
                end
                if (v_o && !v_prev) chk("vo_latency", cyc, done_exp);
                if (v_o && yumi_i) dig_pending = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
                if (abort_i && (cur_active || dig_pending)) begin
                    cur_active = 1'b0; dig_pending = 1'b0;
                end
`endif
            end
            v_prev = v_o;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int acc;
        int nb;
        reset_i = 1'b1; v_i = 1'b0; block_i = '0; last_i = 1'b0; yumi_i = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) step();
        chk("rst_ready", ready_o, 1'b0);
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 1'b1);
        chk("post_rst_round", round_o, 6'd0);
        chk("post_rst_vo", v_o, 1'b0);
        while (cyc < 10) step();

        // Single-block message accepted at cycle 10, digest taken at cycle 80.
        send_block(rnd_blk(), 1'b1, acc);
        chk("acc_cycle", acc, 10);
        wait_vo();
        while (cyc < 80) step();
        take_digest();
        chk("idle_cycle", cyc, 81);
        chk("idle_ready", ready_o, 1'b1);

        // Random multi-block messages with random gaps and consumer delays.
        for (int m = 0; m < 4; m++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 3)) step();
                send_block(rnd_blk(), b == nb - 1, acc);
            end
            wait_vo();
            repeat ($urandom_range(0, 5)) step();
            take_digest();
        end

        // v_i held with changing data through ROUND and DONE, then 20 idle DONE cycles.
        send_block(rnd_blk(), 1'b1, acc);
        for (int i = 0; i < 80; i++) begin
            v_i = 1'b1; block_i = rnd_blk(); last_i = 1'($urandom());
            step();
        end
        v_i = 1'b0;
        repeat (20) step();
        chk("vo_held", v_o, 1'b1);
        take_digest();

        // Spurious yumi between blocks of one message must not restart from the IV.
        send_block(rnd_blk(), 1'b0, acc);
        for (int w = 0; w < 200 && !ready_o; w++) step();
        yumi_i = 1'b1;
        repeat (3) step();
        yumi_i = 1'b0;
        send_block(rnd_blk(), 1'b1, acc);
        wait_vo();
        take_digest();

        // Asynchronous reset at round 30 of the second block of a message.
        send_block(rnd_blk(), 1'b0, acc);
        send_block(rnd_blk(), 1'b0, acc);
        wait_round(30);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_outs", {ready_o, v_o, sched_init_o, comp_load_o, h_init_o,
                               round_v_o, h_update_o, round_o}, '0);
        chk("async_rst_M", sched_M_o, '0);
        q.delete();
        model_first = 1'b1;
        prev_acc    = -1;
        step(); step();
        reset_i = 1'b0;
        repeat (80) step();
        send_block(rnd_blk(), 1'b1, acc);
        wait_vo();
        take_digest();

`ifdef SHA256_CTRL_ABORT_EN
        // Abort at round 40 of a non-first block; the next block restarts from the IV.
        send_block(rnd_blk(), 1'b0, acc);
        send_block(rnd_blk(), 1'b0, acc);
        wait_round(40);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_ready", ready_o, 1'b1);
        chk("abort_round", round_o, 6'd0);
        q.delete();
        model_first = 1'b1;
        prev_acc    = -1;
        send_block(rnd_blk(), 1'b1, acc);
        wait_vo();
        take_digest();
`endif

        repeat (5) step();
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
